// File: rtl/hold_piece_ctrl.sv
// -----------------------------------------------------------------------------
// hold_piece_ctrl
//
// Hold-slot controller for the Tetris game logic. A rising match of the hold
// key stores the falling piece in the hold slot and asks the spawner (over a
// valid/ack handshake) to replace the active piece with the previously held
// shape (0 = take the next piece from the generator). One hold per dropped
// piece: the piece_locked pulse re-arms the hold.
//
// Ports:
//   Clk           system clock
//   Reset_n       asynchronous active-low reset
//   clear         synchronous new-game clear (highest priority after reset)
//   keycode       current keyboard keycode (level)
//   active_shape  shape number of the falling piece (0 = none)
//   piece_locked  one-cycle pulse when the active piece lands
//   spawn_ack     spawner has consumed swap_shape
//   hold_shape    shape held in the slot (0 = empty)
//   hold_used     hold already spent for the current piece
//   swap_valid    request for the spawner to replace the active piece
//   swap_shape    shape to spawn (0 = next from the generator)
//   hold_empty    combinational hold_shape == 0
// -----------------------------------------------------------------------------
module hold_piece_ctrl #(
  parameter logic [7:0] HOLD_KEYCODE = 8'h2C,
  parameter int         SHAPE_W      = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               clear,
  input  logic [7:0]         keycode,
  input  logic [SHAPE_W-1:0] active_shape,
  input  logic               piece_locked,
  input  logic               spawn_ack,
  output logic [SHAPE_W-1:0] hold_shape,
  output logic               hold_used,
  output logic               swap_valid,
  output logic [SHAPE_W-1:0] swap_shape,
  output logic               hold_empty
);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t             state_reg, state_next;
  logic               key_seen_reg, key_seen_next;
  logic [SHAPE_W-1:0] hold_shape_reg, hold_shape_next;
  logic               hold_used_reg, hold_used_next;
  logic               swap_valid_reg, swap_valid_next;
  logic [SHAPE_W-1:0] swap_shape_reg, swap_shape_next;

  logic key_match;
  logic key_hit;
  logic shape_valid;

  assign key_match   = (keycode == HOLD_KEYCODE);
  // A key held for many cycles yields a single hit on its first matching cycle.
  assign key_hit     = key_match & ~key_seen_reg;
  assign shape_valid = (active_shape != '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= IDLE;
      key_seen_reg   <= 1'b0;
      hold_shape_reg <= '0;
      hold_used_reg  <= 1'b0;
      swap_valid_reg <= 1'b0;
      swap_shape_reg <= '0;
    end else if (clear) begin
      state_reg      <= IDLE;
      key_seen_reg   <= 1'b0;
      hold_shape_reg <= '0;
      hold_used_reg  <= 1'b0;
      swap_valid_reg <= 1'b0;
      swap_shape_reg <= '0;
    end else begin
      state_reg      <= state_next;
      key_seen_reg   <= key_seen_next;
      hold_shape_reg <= hold_shape_next;
      hold_used_reg  <= hold_used_next;
      swap_valid_reg <= swap_valid_next;
      swap_shape_reg <= swap_shape_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    key_seen_next   = key_match;
    hold_shape_next = hold_shape_reg;
    hold_used_next  = hold_used_reg;
    swap_valid_next = swap_valid_reg;
    swap_shape_next = swap_shape_reg;

    // A landing piece re-arms the hold regardless of handshake progress.
    if (piece_locked) begin
      hold_used_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        // The lock pulse takes precedence over a simultaneous key hit.
        if (key_hit && !hold_used_reg && !piece_locked && shape_valid) begin
          hold_shape_next = active_shape;
          swap_shape_next = hold_shape_reg;
          hold_used_next  = 1'b1;
          swap_valid_next = 1'b1;
          state_next      = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Key hits here are dropped, not queued.
        if (spawn_ack) begin
          swap_valid_next = 1'b0;
          swap_shape_next = '0;
          state_next      = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign hold_shape = hold_shape_reg;
  assign hold_used  = hold_used_reg;
  assign swap_valid = swap_valid_reg;
  assign swap_shape = swap_shape_reg;
  assign hold_empty = (hold_shape_reg == '0);

endmodule

// File: tb/tb_hold_piece_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hold_piece_ctrl
//
// Table-driven bench for hold_piece_ctrl: each record is one clock cycle of
// inputs plus the outputs expected right after that edge. Reset, clear and the
// asynchronous reset during a pending swap are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_hold_piece_ctrl;

  localparam logic [7:0] KEY = 8'h2C;

  logic       Clk;
  logic       Reset_n;
  logic       clear;
  logic [7:0] keycode;
  logic [2:0] active_shape;
  logic       piece_locked;
  logic       spawn_ack;
  logic [2:0] hold_shape;
  logic       hold_used;
  logic       swap_valid;
  logic [2:0] swap_shape;
  logic       hold_empty;

  int checks_total;
  int checks_passed;

  hold_piece_ctrl #(
    .HOLD_KEYCODE(KEY),
    .SHAPE_W     (3)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .clear       (clear),
    .keycode     (keycode),
    .active_shape(active_shape),
    .piece_locked(piece_locked),
    .spawn_ack   (spawn_ack),
    .hold_shape  (hold_shape),
    .hold_used   (hold_used),
    .swap_valid  (swap_valid),
    .swap_shape  (swap_shape),
    .hold_empty  (hold_empty)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] key;
    logic [2:0] shape;
    logic       lock;
    logic       ack;
    logic [2:0] exp_hold;
    logic       exp_used;
    logic       exp_valid;
    logic [2:0] exp_swap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] key, input logic [2:0] shape,
                     input logic lock, input logic ack,
                     input logic [2:0] eh, input logic eu,
                     input logic ev, input logic [2:0] es);
    vec_t v;
    v.key = key; v.shape = shape; v.lock = lock; v.ack = ack;
    v.exp_hold = eh; v.exp_used = eu; v.exp_valid = ev; v.exp_swap = es;
    vecs.push_back(v);
  endtask

  // Compare all outputs at once; hold_empty is derived from the expected slot.
  task automatic check(input string name, input logic [2:0] eh, input logic eu,
                       input logic ev, input logic [2:0] es);
    logic [8:0] act;
    logic [8:0] exp;
    act = {hold_shape, hold_used, swap_valid, swap_shape, hold_empty};
    exp = {eh, eu, ev, es, (eh == 3'd0)};
    checks_total++;
    if (act === exp) begin
      checks_passed++;
      $display("%s: hold=%0d used=%0b valid=%0b swap=%0d empty=%0b ok",
               name, hold_shape, hold_used, swap_valid, swap_shape, hold_empty);
    end else begin
      $display("FAIL %s: got hold=%0d used=%0b valid=%0b swap=%0d empty=%0b, want hold=%0d used=%0b valid=%0b swap=%0d empty=%0b",
               name, hold_shape, hold_used, swap_valid, swap_shape, hold_empty,
               eh, eu, ev, es, (eh == 3'd0));
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    Reset_n       = 1'b0;
    clear         = 1'b0;
    keycode       = 8'h00;
    active_shape  = 3'd3;
    piece_locked  = 1'b0;
    spawn_ack     = 1'b0;

    //   key   shp lock ack | hold used valid swap
    add(KEY,  3'd3, 0, 0,   3'd3, 1, 1, 3'd0); // first match -> swap next edge
    add(KEY,  3'd3, 0, 0,   3'd3, 1, 1, 3'd0); // key held: no second swap
    add(KEY,  3'd3, 0, 0,   3'd3, 1, 1, 3'd0);
    add(KEY,  3'd3, 0, 0,   3'd3, 1, 1, 3'd0);
    add(KEY,  3'd3, 0, 0,   3'd3, 1, 1, 3'd0);
    add(8'h00,3'd3, 0, 0,   3'd3, 1, 1, 3'd0); // waiting for ack
    add(KEY,  3'd3, 0, 0,   3'd3, 1, 1, 3'd0); // key edge in WAIT_ACK ignored
    add(KEY,  3'd3, 0, 1,   3'd3, 1, 0, 3'd0); // ack -> IDLE
    add(KEY,  3'd3, 0, 0,   3'd3, 1, 0, 3'd0); // no queued hit
    add(8'h00,3'd5, 0, 0,   3'd3, 1, 0, 3'd0);
    add(KEY,  3'd5, 0, 0,   3'd3, 1, 0, 3'd0); // hold spent: no swap
    add(8'h00,3'd5, 1, 0,   3'd3, 0, 0, 3'd0); // lock re-arms
    add(KEY,  3'd5, 0, 0,   3'd5, 1, 1, 3'd3); // swap returns 3
    add(KEY,  3'd5, 0, 1,   3'd5, 1, 0, 3'd0); // ack
    add(8'h00,3'd2, 1, 0,   3'd5, 0, 0, 3'd0); // lock
    add(KEY,  3'd2, 1, 0,   3'd5, 0, 0, 3'd0); // lock and key edge: lock wins
    add(KEY,  3'd2, 0, 0,   3'd5, 0, 0, 3'd0); // still held: no hit
    add(8'h00,3'd0, 0, 0,   3'd5, 0, 0, 3'd0);
    add(KEY,  3'd0, 0, 0,   3'd5, 0, 0, 3'd0); // invalid shape: ignored
    add(8'h00,3'd6, 0, 0,   3'd5, 0, 0, 3'd0);
    add(KEY,  3'd6, 0, 0,   3'd6, 1, 1, 3'd5); // swap returns 5
    add(8'h00,3'd6, 1, 0,   3'd6, 0, 1, 3'd5); // lock clears used in WAIT_ACK

    // Reset state
    #12;
    check("reset", 3'd0, 1'b0, 1'b0, 3'd0);
    Reset_n = 1'b1;
    step();
    check("after_reset_idle", 3'd0, 1'b0, 1'b0, 3'd0);

    foreach (vecs[i]) begin
      keycode      = vecs[i].key;
      active_shape = vecs[i].shape;
      piece_locked = vecs[i].lock;
      spawn_ack    = vecs[i].ack;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp_hold, vecs[i].exp_used,
            vecs[i].exp_valid, vecs[i].exp_swap);
    end

    // clear while hold_shape=6 and a swap is pending
    keycode      = 8'h00;
    piece_locked = 1'b0;
    spawn_ack    = 1'b0;
    clear        = 1'b1;
    step();
    check("clear", 3'd0, 1'b0, 1'b0, 3'd0);
    clear = 1'b0;

    // new hold after clear, then async reset mid-WAIT_ACK
    keycode      = KEY;
    active_shape = 3'd4;
    step();
    check("hold_after_clear", 3'd4, 1'b1, 1'b1, 3'd0);
    keycode = 8'h00;
    #3;
    Reset_n = 1'b0;
    #1;
    check("async_reset", 3'd0, 1'b0, 1'b0, 3'd0);
    #2;
    Reset_n = 1'b1;
    step();
    check("post_reset_idle", 3'd0, 1'b0, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/hold_piece_ctrl.md
Name: hold_piece_ctrl

Overview:
Hold-slot controller for the Tetris game logic. It detects the hold key on the keyboard keycode, stores the active falling shape in the hold slot, and returns the previously held shape to the spawner over a valid/ack handshake. Its hold_shape output drives the hold-preview size lookup and sprite drawer directly. Only one hold is allowed per dropped piece.

Parameters:
HOLD_KEYCODE, 8'h2C, USB keycode that triggers a hold (space bar by default).
SHAPE_W, 3, shape-number width; 0 = empty/none, 1..7 = valid tetromino.

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous new-game clear; highest priority after reset
keycode  in  8  current keyboard keycode (level, may stay asserted many cycles)
active_shape  in  3  shape number of the currently falling piece
piece_locked  in  1  one-cycle pulse when the active piece lands
spawn_ack  in  1  spawner has consumed swap_shape
hold_shape  out  3  shape held in the slot (0 = empty); feeds the hold-preview size lookup
hold_used  out  1  hold already spent for the current piece
swap_valid  out  1  request for the spawner to replace the active piece
swap_shape  out  3  shape to spawn; 0 = spawner takes the next piece from the generator
hold_empty  out  1  combinational: hold_shape == 0

Behaviour:
- One clock domain. Reset is asynchronous and active-low, named Reset_n; the clock is named Clk.
- Values on reset (Reset_n=0) or on clear=1 at a Clk edge: hold_shape=0, hold_used=0, swap_valid=0, swap_shape=0, state=IDLE, key_seen=0.
- Edge detect:
  - key_match = (keycode == HOLD_KEYCODE).
  - key_seen is a register that takes key_match every cycle in every state.
  - key_hit = key_match & ~key_seen, so a held key produces exactly one hit.
- FSM states: IDLE, WAIT_ACK.
- IDLE:
  - A hold fires when key_hit=1, hold_used=0, piece_locked=0 and active_shape is in 1..7.
  - On the next edge after a hold fires:
    - hold_shape <= active_shape
    - swap_shape <= previous hold_shape
    - hold_used <= 1
    - swap_valid <= 1
    - state <= WAIT_ACK
  - Latency: swap_valid rises exactly 1 cycle after keycode first matches.
- WAIT_ACK:
  - swap_valid=1. swap_shape and hold_shape stay stable.
  - When spawn_ack=1: swap_valid <= 0, swap_shape <= 0, state <= IDLE.
  - Key hits are ignored in this state, and no hit is queued.
  - spawn_ack is ignored in IDLE.
- piece_locked=1 clears hold_used on the next edge, in any state.
  - If piece_locked and key_hit occur in the same IDLE cycle, the lock wins: no swap, hold_used <= 0.
- Invalid active_shape (0): key_hit is ignored, no state change.
- Reset_n or clear during WAIT_ACK: swap_valid drops immediately (async for Reset_n, next edge for clear); the pending swap is discarded.
- hold_shape only ever holds 0..7 and is never written with 0 by a swap.

Test Plan:
1. Reset -> all outputs 0, hold_empty=1. active_shape=3, keycode=8'h2C held for 10 cycles -> a single swap: cycle+1 swap_valid=1, swap_shape=0, hold_shape=3, hold_used=1.
2. Continuing from 1: hold spawn_ack=0 for 5 cycles -> swap_valid stays 1 and outputs stay stable. spawn_ack=1 -> next cycle swap_valid=0, state IDLE.
3. hold_used=1, release then re-press the key with active_shape=5 -> no swap, hold_shape stays 3. Pulse piece_locked -> hold_used=0. Press again -> swap_shape=3, hold_shape=5.
4. piece_locked and a key edge in the same cycle with hold_used=0 -> no swap_valid, hold_used=0, hold_shape unchanged.
5. Key edge while active_shape=0 -> no change. Key edge while in WAIT_ACK -> ignored; after the ack no extra swap occurs.
6. Deassert Reset_n mid-WAIT_ACK -> swap_valid=0 asynchronously and hold_shape=0. clear=1 with hold_shape=6 -> next edge all outputs 0.
